// File: rtl/io_map_pkg.sv
// Address map, status layout and region constants for the memory-mapped I/O slave.
package io_map_pkg;

   localparam logic [3:0] IO_REGION = 4'h8;

   localparam logic [7:0] UART_CTRL = 8'h00;
   localparam logic [7:0] UART_RX   = 8'h04;
   localparam logic [7:0] UART_TX   = 8'h08;
   localparam logic [7:0] CYC_CNT   = 8'h10;
   localparam logic [7:0] INST_CNT  = 8'h14;
   localparam logic [7:0] CNT_RST   = 8'h18;

   localparam int ST_TX_NOTFULL  = 0;
   localparam int ST_RX_NONEMPTY = 1;

   // Packed so that it drops straight into the low two bits of the status word.
   typedef struct packed {
      logic rx_nonempty;
      logic tx_notfull;
   } uart_status_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head is valid whenever empty is low.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == CNT_FULL);
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Pointers wrap on their own; the extra count bit separates full from empty.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/mmio_uart_controller.sv
// I/O slave at region 0x8: UART RX/TX byte FIFOs plus cycle and retired-instruction counters.
module mmio_uart_controller
   import io_map_pkg::*;
#(
   parameter int RX_DEPTH = 8,
   parameter int TX_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] io_addr,
   input  logic [31:0] io_wdata,
   input  logic        io_we,
   input  logic        io_re,
   input  logic        inst_retire,
   output logic [31:0] io_rdata,
   output logic [7:0]  uart_tx_data,
   output logic        uart_tx_valid,
   input  logic        uart_tx_ready,
   input  logic [7:0]  uart_rx_data,
   input  logic        uart_rx_valid,
   output logic        uart_rx_ready
);

   logic        io_sel;
   logic [7:0]  offset;
   logic        tx_push;
   logic        tx_pop;
   logic        tx_full;
   logic        tx_empty;
   logic [7:0]  tx_head;
   logic        rx_push;
   logic        rx_pop;
   logic        rx_full;
   logic        rx_empty;
   logic [7:0]  rx_head;
   logic        cnt_clr;
   logic [31:0] cycle_cnt;
   logic [31:0] instr_cnt;
   logic [31:0] rd_mux;
   uart_status_t status;
   logic        unused_bits;

   assign io_sel      = (io_addr[31:28] == IO_REGION);
   assign offset      = io_addr[7:0];
   assign unused_bits = &{1'b0, io_addr[27:8], io_wdata[31:8]};

   assign tx_push = io_we && io_sel && (offset == UART_TX);
   assign cnt_clr = io_we && io_sel && (offset == CNT_RST);
   assign rx_pop  = io_re && io_sel && (offset == UART_RX) && !rx_empty;

   // Both UART links use valid/ready: a byte moves on a cycle where valid and
   // ready are both high; the sender holds data and valid stable until then.
   assign uart_rx_ready = !rx_full;
   assign rx_push       = uart_rx_valid && uart_rx_ready;
   assign uart_tx_valid = !tx_empty;
   assign uart_tx_data  = tx_head;
   assign tx_pop        = uart_tx_valid && uart_tx_ready;

   sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (rx_push),
      .push_data (uart_rx_data),
      .pop       (rx_pop),
      .head      (rx_head),
      .full      (rx_full),
      .empty     (rx_empty)
   );

   sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (tx_push),
      .push_data (io_wdata[7:0]),
      .pop       (tx_pop),
      .head      (tx_head),
      .full      (tx_full),
      .empty     (tx_empty)
   );

   // Status comes from FIFO flags before any push/pop of this cycle.
   assign status.rx_nonempty = !rx_empty;
   assign status.tx_notfull  = !tx_full;

   always_comb begin
      rd_mux = '0;
      if (io_sel) begin
         case (offset)
            UART_CTRL: rd_mux = {30'b0, status};
            UART_RX:   rd_mux = rx_empty ? 32'h0 : {24'b0, rx_head};
            CYC_CNT:   rd_mux = cycle_cnt;
            INST_CNT:  rd_mux = instr_cnt;
            default:   rd_mux = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         io_rdata <= '0;
      end else if (io_re) begin
         io_rdata <= rd_mux;
      end
   end

   // Clear has priority over counting in the same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cycle_cnt <= '0;
         instr_cnt <= '0;
      end else if (cnt_clr) begin
         cycle_cnt <= '0;
         instr_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 32'd1;
         if (inst_retire) instr_cnt <= instr_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_mmio_uart_controller.sv
// Directed bench for mmio_uart_controller: vector table plus hand sequences for multi-cycle cases.
module tb_mmio_uart_controller;

   localparam logic [31:0] A_CTRL = 32'h8000_0000;
   localparam logic [31:0] A_RX   = 32'h8000_0004;
   localparam logic [31:0] A_TX   = 32'h8000_0008;
   localparam logic [31:0] A_GAP  = 32'h8000_000C;
   localparam logic [31:0] A_CYC  = 32'h8000_0010;
   localparam logic [31:0] A_INST = 32'h8000_0014;
   localparam logic [31:0] A_CLR  = 32'h8000_0018;

   logic        clk;
   logic        rst;
   logic [31:0] io_addr;
   logic [31:0] io_wdata;
   logic        io_we;
   logic        io_re;
   logic        inst_retire;
   logic [31:0] io_rdata;
   logic [7:0]  uart_tx_data;
   logic        uart_tx_valid;
   logic        uart_tx_ready;
   logic [7:0]  uart_rx_data;
   logic        uart_rx_valid;
   logic        uart_rx_ready;

   int total;
   int bad;
   logic [7:0] exp_q[$];

   typedef struct {
      logic        we;
      logic        re;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        rxv;
      logic [7:0]  rxd;
      logic        txr;
      logic [31:0] exp_rdata;
      logic        exp_txv;
      logic [7:0]  exp_txd;
      logic        exp_rxr;
   } vec_t;

   vec_t vecs[$];

   mmio_uart_controller #(.RX_DEPTH(8), .TX_DEPTH(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .io_addr       (io_addr),
      .io_wdata      (io_wdata),
      .io_we         (io_we),
      .io_re         (io_re),
      .inst_retire   (inst_retire),
      .io_rdata      (io_rdata),
      .uart_tx_data  (uart_tx_data),
      .uart_tx_valid (uart_tx_valid),
      .uart_tx_ready (uart_tx_ready),
      .uart_rx_data  (uart_rx_data),
      .uart_rx_valid (uart_rx_valid),
      .uart_rx_ready (uart_rx_ready)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
      end
   endtask

   // drivers: all inputs change just after a falling edge, outputs are sampled at the next one
   task automatic idle();
      io_we         = 1'b0;
      io_re         = 1'b0;
      io_addr       = A_CTRL;
      io_wdata      = '0;
      uart_rx_valid = 1'b0;
      uart_rx_data  = '0;
      uart_tx_ready = 1'b0;
      inst_retire   = 1'b0;
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic rd(input logic [31:0] addr);
      io_re   = 1'b1;
      io_addr = addr;
      step();
      io_re   = 1'b0;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      io_we    = 1'b1;
      io_addr  = addr;
      io_wdata = data;
      step();
      io_we    = 1'b0;
   endtask

   initial begin
      int popped;
      total = 0;
      bad   = 0;
      idle();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_rdata", io_rdata, 32'h0);
      check("reset_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
      check("reset_rx_ready", {31'b0, uart_rx_ready}, 32'h1);
      rst = 1'b1;
      step();

      //              we re addr    wdata          rxv rxd    txr  rdata          txv txd    rxr
      vecs.push_back('{0, 1, A_CTRL, 32'h0,         0, 8'h00, 0, 32'h0000_0001, 0, 8'h00, 1});
      vecs.push_back('{0, 0, A_CTRL, 32'h0,         1, 8'h41, 0, 32'h0000_0001, 0, 8'h00, 1});
      vecs.push_back('{0, 0, A_CTRL, 32'h0,         1, 8'h42, 0, 32'h0000_0001, 0, 8'h00, 1});
      vecs.push_back('{0, 1, A_CTRL, 32'h0,         0, 8'h00, 0, 32'h0000_0003, 0, 8'h00, 1});
      vecs.push_back('{0, 1, A_RX,   32'h0,         0, 8'h00, 0, 32'h0000_0041, 0, 8'h00, 1});
      vecs.push_back('{0, 1, A_RX,   32'h0,         0, 8'h00, 0, 32'h0000_0042, 0, 8'h00, 1});
      vecs.push_back('{0, 1, A_RX,   32'h0,         0, 8'h00, 0, 32'h0000_0000, 0, 8'h00, 1});
      vecs.push_back('{0, 1, A_CTRL, 32'h0,         0, 8'h00, 0, 32'h0000_0001, 0, 8'h00, 1});
      vecs.push_back('{1, 0, A_TX,   32'h1234_56A5, 0, 8'h00, 0, 32'h0000_0001, 1, 8'hA5, 1});
      vecs.push_back('{0, 1, A_CTRL, 32'h0,         0, 8'h00, 0, 32'h0000_0001, 1, 8'hA5, 1});
      vecs.push_back('{0, 0, A_CTRL, 32'h0,         0, 8'h00, 1, 32'h0000_0001, 0, 8'h00, 1});
      vecs.push_back('{1, 1, A_TX,   32'h0000_005C, 0, 8'h00, 0, 32'h0000_0000, 1, 8'h5C, 1});
      vecs.push_back('{0, 1, A_GAP,  32'h0,         0, 8'h00, 1, 32'h0000_0000, 0, 8'h00, 1});
      vecs.push_back('{0, 1, A_RX,   32'h0,         1, 8'h77, 0, 32'h0000_0000, 0, 8'h00, 1});
      vecs.push_back('{0, 1, A_CTRL, 32'h0,         0, 8'h00, 0, 32'h0000_0003, 0, 8'h00, 1});
      vecs.push_back('{0, 1, A_RX,   32'h0,         1, 8'h88, 0, 32'h0000_0077, 0, 8'h00, 1});
      vecs.push_back('{0, 1, A_RX,   32'h0,         0, 8'h00, 0, 32'h0000_0088, 0, 8'h00, 1});
      vecs.push_back('{0, 1, A_CTRL, 32'h0,         0, 8'h00, 0, 32'h0000_0001, 0, 8'h00, 1});
      vecs.push_back('{0, 1, 32'h8000_0F14, 32'h0,  0, 8'h00, 0, 32'h0000_0000, 0, 8'h00, 1});
      vecs.push_back('{0, 1, 32'h8000_0100, 32'h0,  0, 8'h00, 0, 32'h0000_0001, 0, 8'h00, 1});

      for (int i = 0; i < vecs.size(); i++) begin
         io_we         = vecs[i].we;
         io_re         = vecs[i].re;
         io_addr       = vecs[i].addr;
         io_wdata      = vecs[i].wdata;
         uart_rx_valid = vecs[i].rxv;
         uart_rx_data  = vecs[i].rxd;
         uart_tx_ready = vecs[i].txr;
         step();
         check($sformatf("vec%0d_rdata", i), io_rdata, vecs[i].exp_rdata);
         check($sformatf("vec%0d_tx_valid", i), {31'b0, uart_tx_valid}, {31'b0, vecs[i].exp_txv});
         check($sformatf("vec%0d_rx_ready", i), {31'b0, uart_rx_ready}, {31'b0, vecs[i].exp_rxr});
         if (vecs[i].exp_txv)
            check($sformatf("vec%0d_tx_data", i), {24'b0, uart_tx_data}, {24'b0, vecs[i].exp_txd});
      end
      idle();

      // TX: nine writes with the UART stalled; the ninth finds the FIFO full
      for (int i = 0; i < 9; i++) begin
         wr(A_TX, 32'h10 + 32'(i));
         if (i < 8) exp_q.push_back(8'h10 + 8'(i));
         if (i == 7) begin
            rd(A_CTRL);
            check("tx_full_status", io_rdata, 32'h0);
         end
      end
      uart_tx_ready = 1'b1;
      popped = 0;
      for (int c = 0; c < 20 && uart_tx_valid; c++) begin
         if (exp_q.size() == 0) begin
            check("tx_extra_byte", {24'b0, uart_tx_data}, 32'hFFFF_FFFF);
         end else begin
            check($sformatf("tx_drain%0d", popped), {24'b0, uart_tx_data}, {24'b0, exp_q.pop_front()});
         end
         popped++;
         step();
      end
      check("tx_drain_count", 32'(popped), 32'd8);
      check("tx_empty_after", {31'b0, uart_tx_valid}, 32'h0);
      idle();

      // RX: fill to eight, then pop one while the UART keeps offering a byte
      for (int i = 0; i < 8; i++) begin
         uart_rx_valid = 1'b1;
         uart_rx_data  = 8'h20 + 8'(i);
         step();
         check($sformatf("rx_fill%0d_ready", i), {31'b0, uart_rx_ready}, (i < 7) ? 32'h1 : 32'h0);
      end
      uart_rx_data = 8'h28;
      rd(A_RX);
      check("rx_pop_full_data", io_rdata, 32'h20);
      check("rx_ready_after_pop", {31'b0, uart_rx_ready}, 32'h1);
      step();
      check("rx_refilled_ready", {31'b0, uart_rx_ready}, 32'h0);
      uart_rx_valid = 1'b0;
      for (int i = 1; i <= 8; i++) exp_q.push_back(8'h20 + 8'(i));
      for (int i = 0; i < 8; i++) begin
         rd(A_RX);
         check($sformatf("rx_drain%0d", i), io_rdata, {24'b0, exp_q.pop_front()});
      end
      rd(A_RX);
      check("rx_empty_read", io_rdata, 32'h0);

      // Counters: ten retire cycles, clear while retire is still high
      inst_retire = 1'b1;
      repeat (10) step();
      inst_retire = 1'b0;
      rd(A_INST);
      check("instr_cnt_10", io_rdata, 32'd10);
      inst_retire = 1'b1;
      wr(A_CLR, 32'hDEAD_BEEF);
      inst_retire = 1'b0;
      rd(A_INST);
      check("instr_after_clear", io_rdata, 32'h0);
      repeat (5) step();
      // value 0 after the clear edge, then +1 at each of the six edges that follow
      rd(A_CYC);
      check("cycle_since_clear", io_rdata, 32'd6);

      // Wrap: preload the cycle counter with all ones
      io_re   = 1'b1;
      io_addr = A_CYC;
      force dut.cycle_cnt = 32'hFFFF_FFFF;
      #1 release dut.cycle_cnt;
      step();
      check("cycle_at_max", io_rdata, 32'hFFFF_FFFF);
      step();
      check("cycle_wrapped", io_rdata, 32'h0);
      idle();

      // Reset in the middle of a TX burst
      wr(A_TX, 32'h61);
      wr(A_TX, 32'h62);
      rd(A_CTRL);
      check("pre_reset_tx_valid", {31'b0, uart_tx_valid}, 32'h1);
      check("pre_reset_rdata", io_rdata, 32'h1);
      #2 rst = 1'b0;
      #1;
      check("async_reset_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
      check("async_reset_rdata", io_rdata, 32'h0);
      check("async_reset_rx_ready", {31'b0, uart_rx_ready}, 32'h1);
      @(negedge clk);
      rst = 1'b1;
      step();
      check("post_reset_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
      rd(A_CTRL);
      check("post_reset_status", io_rdata, 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
